ql_cfg_scan_ctrl: RTL and testbench

QL_CFG_SCAN_CTRL -- requirements
Module: ql_cfg_scan_ctrl

---
 rtl/ql_cfg_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_ql_cfg_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ql_cfg_scan_ctrl.sv
// Word-to-serial loader for a QuickLogic-style configuration scan chain.
// Optional even-parity check on incoming words is enabled by QL_CFG_SCAN_PARITY_EN.
`timescale 1ns/1ps
module ql_cfg_scan_ctrl #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 16
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
`ifdef QL_CFG_SCAN_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              in_ready,
  output logic              scan_out,
  output logic              scan_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bit_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic              last_chain, last_word;

`ifdef QL_CFG_SCAN_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`endif

  // The bit being shifted this cycle is the final one of the chain / of the word.
  assign last_chain = (bit_cnt_q + 16'd1) == 16'(CHAIN_LEN);
  assign last_word  = wcnt_q == 6'(WORD_W - 1);

  always_ff @(posedge clk) begin
    if (R) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      wcnt_q    <= '0;
`ifdef QL_CFG_SCAN_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      wcnt_q    <= wcnt_d;
`ifdef QL_CFG_SCAN_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    wcnt_d    = wcnt_q;
`ifdef QL_CFG_SCAN_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          bit_cnt_d = '0;
`ifdef QL_CFG_SCAN_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
`ifdef QL_CFG_SCAN_PARITY_EN
          if (in_par != ^in_data) begin
            state_d   = StIdle;
            par_err_d = 1'b1;
          end else begin
            shreg_d = in_data;
            wcnt_d  = '0;
            state_d = StShift;
          end
`else
          shreg_d = in_data;
          wcnt_d  = '0;
          state_d = StShift;
`endif
        end
      end
      StShift: begin
        // The abort cycle still shifts its bit: scan_en is already high.
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 16'd1;
        wcnt_d    = wcnt_q + 6'd1;
        if (abort)           state_d = StIdle;
        else if (last_chain) state_d = StDone;
        else if (last_word)  state_d = StLoad;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready = (state_q == StLoad) && !abort;
  assign scan_en  = state_q == StShift;
  assign scan_out = scan_en & shreg_q[0];
  assign busy     = state_q != StIdle;
  assign done     = state_q == StDone;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_ql_cfg_scan_ctrl.sv
// Directed self-checking bench for ql_cfg_scan_ctrl: a 20-bit/8-bit-word instance and a
// 16-bit/16-bit-word instance; parity cases run when QL_CFG_SCAN_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_ql_cfg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: CHAIN_LEN=20, WORD_W=8
  logic        a_r, a_start, a_abort, a_valid, a_par;
  logic [7:0]  a_data;
  logic        a_ready, a_sout, a_sen, a_busy, a_done;
  logic [15:0] a_cnt;
`ifdef QL_CFG_SCAN_PARITY_EN
  logic        a_perr;
`endif

  ql_cfg_scan_ctrl #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
    .clk     (clk),
    .R       (a_r),
    .start   (a_start),
    .abort   (a_abort),
    .in_data (a_data),
    .in_valid(a_valid),
`ifdef QL_CFG_SCAN_PARITY_EN
    .in_par  (a_par),
    .par_err (a_perr),
`endif
    .in_ready(a_ready),
    .scan_out(a_sout),
    .scan_en (a_sen),
    .busy    (a_busy),
    .done    (a_done),
    .bit_cnt (a_cnt)
  );

  // Instance B: CHAIN_LEN=16, WORD_W=16
  logic        b_r, b_start, b_abort, b_valid, b_par;
  logic [15:0] b_data;
  logic        b_ready, b_sout, b_sen, b_busy, b_done;
  logic [15:0] b_cnt;
`ifdef QL_CFG_SCAN_PARITY_EN
  logic        b_perr;
`endif

  ql_cfg_scan_ctrl #(.CHAIN_LEN(16), .WORD_W(16)) dut_b (
    .clk     (clk),
    .R       (b_r),
    .start   (b_start),
    .abort   (b_abort),
    .in_data (b_data),
    .in_valid(b_valid),
`ifdef QL_CFG_SCAN_PARITY_EN
    .in_par  (b_par),
    .par_err (b_perr),
`endif
    .in_ready(b_ready),
    .scan_out(b_sout),
    .scan_en (b_sen),
    .busy    (b_busy),
    .done    (b_done),
    .bit_cnt (b_cnt)
  );

  // Stream monitors: first shifted bit ends up most significant.
  logic [31:0] a_stream = '0, b_stream = '0;
  int a_en = 0, a_dn = 0, a_leak = 0, b_en = 0, b_dn = 0;

  always @(negedge clk) begin
    if (a_sen) begin
      a_stream <= {a_stream[30:0], a_sout};
      a_en     <= a_en + 1;
    end
    if (!a_sen && a_sout) a_leak <= a_leak + 1;
    if (a_done) a_dn <= a_dn + 1;
    if (b_sen) begin
      b_stream <= {b_stream[30:0], b_sout};
      b_en     <= b_en + 1;
    end
    if (b_done) b_dn <= b_dn + 1;
  end

  int en0, dn0;

  task automatic a_pulse_start();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_send_p(input logic [7:0] w, input logic p);
    bit ok = 1'b0;
    a_data  = w;
    a_par   = p;
    a_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    a_valid = 1'b0;
    check_eq("a_accept", ok, 1);
  endtask

  task automatic a_send(input logic [7:0] w);
    a_send_p(w, ^w);
  endtask

  task automatic a_wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!a_busy) ok = 1'b1;
    end
    check_eq("a_idle", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic a_full_load(input string tag);
    en0 = a_en; dn0 = a_dn;
    a_pulse_start();
    a_send(8'hA5);
    a_send(8'h3C);
    a_send(8'h0F);
    a_wait_idle();
    check_eq({tag, "_en"}, a_en - en0, 20);
    check_eq({tag, "_done"}, a_dn - dn0, 1);
    check_eq({tag, "_stream"}, {12'h0, a_stream[19:0]}, 32'h000A53CF);
    check_eq({tag, "_cnt"}, a_cnt, 20);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    a_r = 1; a_start = 0; a_abort = 0; a_valid = 0; a_data = '0; a_par = 0;
    b_r = 1; b_start = 0; b_abort = 0; b_valid = 0; b_data = '0; b_par = 0;
    repeat (3) @(posedge clk);
    #1; a_r = 0; b_r = 0;
    @(negedge clk);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_ready", a_ready, 0);
    check_eq("rst_sen", a_sen, 0);
    check_eq("rst_sout", a_sout, 0);
    check_eq("rst_done", a_done, 0);
    check_eq("rst_cnt", a_cnt, 0);
    check_eq("rst_b_busy", b_busy, 0);

    // Three 8-bit words into a 20-bit chain; last word truncated to 4 bits.
    a_full_load("load20");

    // 16-bit word, long idle gap before in_valid.
    en0 = b_en; dn0 = b_dn;
    b_start = 1; @(posedge clk); #1; b_start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("gap_ready", b_ready, 1);
      check_eq("gap_sen", b_sen, 0);
    end
    @(posedge clk); #1;
    b_data = 16'hFFFF; b_par = 1'b0; b_valid = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (b_ready) begin @(posedge clk); #1; ok = 1; end
    end
    b_valid = 0;
    check_eq("b_accept", ok, 1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!b_busy) ok = 1;
    end
    check_eq("b_idle", ok, 1);
    @(posedge clk); #1;
    check_eq("b_en", b_en - en0, 16);
    check_eq("b_stream", {16'h0, b_stream[15:0]}, 32'h0000FFFF);
    check_eq("b_done", b_dn - dn0, 1);
    check_eq("b_cnt", b_cnt, 16);

    // Abort in the 5th shift cycle of the first word.
    en0 = a_en; dn0 = a_dn;
    a_pulse_start();
    a_send(8'hA5);
    repeat (4) @(posedge clk);
    #1; a_abort = 1;
    @(posedge clk); #1; a_abort = 0;
    @(negedge clk);
    check_eq("abort_busy", a_busy, 0);
    check_eq("abort_cnt", a_cnt, 5);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_en", a_en - en0, 5);
    check_eq("abort_done", a_dn - dn0, 0);
    check_eq("abort_stream", {27'h0, a_stream[4:0]}, 32'h14);

    // Reset in the middle of SHIFT, then a clean load.
    a_pulse_start();
    a_send(8'hA5);
    repeat (2) @(posedge clk);
    #1; a_r = 1;
    @(posedge clk); #1; a_r = 0;
    @(negedge clk);
    check_eq("mrst_busy", a_busy, 0);
    check_eq("mrst_sen", a_sen, 0);
    check_eq("mrst_sout", a_sout, 0);
    check_eq("mrst_ready", a_ready, 0);
    check_eq("mrst_done", a_done, 0);
    check_eq("mrst_cnt", a_cnt, 0);
    a_full_load("after_rst");

    // Start while busy is ignored.
    en0 = a_en; dn0 = a_dn;
    a_pulse_start();
    a_send(8'hA5);
    a_start = 1; @(posedge clk); #1; a_start = 0;
    a_send(8'h3C);
    a_send(8'h0F);
    a_wait_idle();
    check_eq("busy_start_en", a_en - en0, 20);
    check_eq("busy_start_stream", {12'h0, a_stream[19:0]}, 32'h000A53CF);
    check_eq("busy_start_cnt", a_cnt, 20);

    // Start with abort in IDLE begins a load.
    a_start = 1; a_abort = 1;
    @(posedge clk); #1; a_start = 0; a_abort = 0;
    @(negedge clk);
    check_eq("sa_busy", a_busy, 1);
    check_eq("sa_ready", a_ready, 1);
    check_eq("sa_cnt", a_cnt, 0);
    @(posedge clk); #1; a_abort = 1;
    @(posedge clk); #1; a_abort = 0;
    @(negedge clk);
    check_eq("sa_abort_busy", a_busy, 0);

`ifdef QL_CFG_SCAN_PARITY_EN
    en0 = a_en;
    a_pulse_start();
    a_send_p(8'h01, 1'b0);
    @(negedge clk);
    check_eq("par_busy", a_busy, 0);
    check_eq("par_err_set", a_perr, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("par_no_shift", a_en - en0, 0);
    a_pulse_start();
    @(negedge clk);
    check_eq("par_err_clr", a_perr, 0);
    a_send_p(8'h01, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("par_ok_en", a_en - en0, 8);
    check_eq("par_ok_stream", {24'h0, a_stream[7:0]}, 32'h80);
    check_eq("par_ok_err", a_perr, 0);
    a_abort = 1; @(posedge clk); #1; a_abort = 0;
`endif

    check_eq("sout_leak", a_leak, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
